// File: rtl/mlb_result_unpacker.sv
// -----------------------------------------------------------------------------
// mlb_result_unpacker
//
// Purpose:
//   Splits the packed product word of the configurable multiplier into 1, 2 or
//   4 lanes, extends each lane to ACC_W bits and accumulates it into a per-lane
//   accumulator over a group of beats. When the last beat of a group has been
//   accepted, the per-lane sums are streamed out one lane per output handshake,
//   lane 0 first.
//
// Parameters:
//   C_W    width of the packed product word (lanes are taken from bits [15:0])
//   ACC_W  per-lane accumulator / output width (16..48)
//
// Configuration macro:
//   MLB_UNPACK_SATURATE_EN  when defined, accumulators saturate to the signed or
//                           unsigned ACC_W-bit range (per latched sign) instead
//                           of wrapping modulo 2^ACC_W.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   reset      synchronous active-high reset
//   in_c       packed product word
//   in_mode    0: one 16-bit lane, 1: two 8-bit lanes, 2: four 4-bit lanes,
//              3: treated as 0
//   in_signed  lanes are two's complement (1) or unsigned (0)
//   in_valid   input beat valid
//   in_last    final beat of an accumulation group
//   in_ready   block accepts an input beat this cycle
//   out_data   accumulated sum of lane out_lane
//   out_lane   lane index of out_data
//   out_last   final lane of the group
//   out_valid  output beat valid
//   out_ready  downstream accepts the output beat
// -----------------------------------------------------------------------------
module mlb_result_unpacker #(
    parameter int C_W   = 16,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [C_W-1:0]   in_c,
    input  logic [1:0]       in_mode,
    input  logic             in_signed,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [1:0]       out_lane,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [ACC_W-1:0] r_acc [4];
    logic [1:0]       r_mode;     // latched (normalised) mode of current group
    logic             r_signed;   // latched sign of current group
    logic             r_open;     // a group has started (mode/sign latched)
    logic [1:0]       r_lane;     // lane index being drained

    logic [15:0]      w_c16;
    logic [1:0]       w_mode_in;
    logic [1:0]       w_mode;
    logic             w_sgn;
    logic [ACC_W-1:0] w_lane_val [4];
    logic [1:0]       w_last_idx;
    logic             w_is_last;
    logic             w_in_fire;
    logic             w_out_fire;

    // -------------------------------------------------------------------------
    // Lane extension helpers
    // -------------------------------------------------------------------------
    function automatic logic [ACC_W-1:0] ext4(input logic [3:0] v, input logic s);
        ext4 = s ? ACC_W'($signed(v)) : ACC_W'(v);
    endfunction

    function automatic logic [ACC_W-1:0] ext8(input logic [7:0] v, input logic s);
        ext8 = s ? ACC_W'($signed(v)) : ACC_W'(v);
    endfunction

    function automatic logic [ACC_W-1:0] ext16(input logic [15:0] v, input logic s);
        ext16 = s ? ACC_W'($signed(v)) : ACC_W'(v);
    endfunction

    // -------------------------------------------------------------------------
    // Accumulator update
    // -------------------------------------------------------------------------
`ifdef MLB_UNPACK_SATURATE_EN
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b,
                                                 input logic s);
        logic [ACC_W:0] sum;
        if (s) begin
            sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
            // Overflow when the extra sign bit disagrees with the MSB.
            if (sum[ACC_W] != sum[ACC_W-1])
                acc_add = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
            else
                acc_add = sum[ACC_W-1:0];
        end else begin
            sum = {1'b0, a} + {1'b0, b};
            acc_add = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
        end
    endfunction
`else
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        acc_add = a + b;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Lane split
    // -------------------------------------------------------------------------
    assign w_c16     = in_c[15:0];
    assign w_mode_in = (in_mode == 2'd3) ? 2'd0 : in_mode;
    // The first beat of a group uses its own mode/sign; later beats use the
    // values latched from that first beat.
    assign w_mode    = r_open ? r_mode   : w_mode_in;
    assign w_sgn     = r_open ? r_signed : in_signed;

    always_comb begin
        for (int k = 0; k < 4; k++) w_lane_val[k] = '0;
        case (w_mode)
            2'd1: begin
                w_lane_val[0] = ext8(w_c16[7:0],  w_sgn);
                w_lane_val[1] = ext8(w_c16[15:8], w_sgn);
            end
            2'd2: begin
                w_lane_val[0] = ext4(w_c16[3:0],   w_sgn);
                w_lane_val[1] = ext4(w_c16[7:4],   w_sgn);
                w_lane_val[2] = ext4(w_c16[11:8],  w_sgn);
                w_lane_val[3] = ext4(w_c16[15:12], w_sgn);
            end
            default: begin
                w_lane_val[0] = ext16(w_c16, w_sgn);
            end
        endcase
    end

    always_comb begin
        case (r_mode)
            2'd1:    w_last_idx = 2'd1;
            2'd2:    w_last_idx = 2'd3;
            default: w_last_idx = 2'd0;
        endcase
    end

    assign w_is_last = (r_lane == w_last_idx);

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ACCUM;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = !reset;
                if (in_valid && in_last)
                    w_state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = !reset;
                if (out_ready && w_is_last)
                    w_state_nxt = ACCUM;
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    assign w_in_fire  = in_valid  && in_ready;
    assign w_out_fire = out_valid && out_ready;

    // -------------------------------------------------------------------------
    // Accumulators, latched group attributes and drain lane index
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) r_acc[k] <= '0;
            r_mode   <= 2'd0;
            r_signed <= 1'b0;
            r_open   <= 1'b0;
            r_lane   <= 2'd0;
        end else begin
            if (w_in_fire) begin
                for (int k = 0; k < 4; k++) begin
`ifdef MLB_UNPACK_SATURATE_EN
                    r_acc[k] <= acc_add(r_acc[k], w_lane_val[k], w_sgn);
`else
                    r_acc[k] <= acc_add(r_acc[k], w_lane_val[k]);
`endif
                end
                if (!r_open) begin
                    r_mode   <= w_mode_in;
                    r_signed <= in_signed;
                end
                // Closing the group here lets the next group latch afresh,
                // while r_mode stays valid for the drain in between.
                r_open <= !in_last;
            end
            if (w_out_fire) begin
                if (w_is_last) begin
                    for (int k = 0; k < 4; k++) r_acc[k] <= '0;
                    r_lane <= 2'd0;
                    r_open <= 1'b0;
                end else begin
                    r_lane <= r_lane + 2'd1;
                end
            end
        end
    end

    // Outputs are forced to zero whenever no output beat is offered.
    assign out_data = out_valid ? r_acc[r_lane] : '0;
    assign out_lane = out_valid ? r_lane        : 2'd0;
    assign out_last = out_valid && w_is_last;

endmodule

// File: tb/tb_mlb_result_unpacker.sv
module tb_mlb_result_unpacker;

    localparam int C_W   = 16;
    localparam int ACC_W = 24;

    logic             clk = 1'b0;
    logic             reset;
    logic [C_W-1:0]   in_c;
    logic [1:0]       in_mode;
    logic             in_signed;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [ACC_W-1:0] out_data;
    logic [1:0]       out_lane;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ACC_W-1:0] d;
        logic [1:0]       lane;
        logic             last;
    } exp_t;

    exp_t   q[$];
    int     rdy_mode;   // 0 random, 1 forced low, 2 forced high

    // Reference model state: one group in progress
    bit     m_open;
    int     m_mode;
    bit     m_sgn;
    longint m_sum [4];

    mlb_result_unpacker #(.C_W(C_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_c      (in_c),
        .in_mode   (in_mode),
        .in_signed (in_signed),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_open = 0;
        m_mode = 0;
        m_sgn  = 0;
        for (int k = 0; k < 4; k++) m_sum[k] = 0;
    endtask

    // Lane arithmetic from the packing rules: width 16>>mode, count 1<<mode.
    task automatic model_beat(input logic [15:0] c, input int mode, input bit sgn, input bit last);
        int     w;
        int     nl;
        longint v;
        exp_t   e;
        if (!m_open) begin
            m_mode = (mode == 3) ? 0 : mode;
            m_sgn  = sgn;
            m_open = 1;
        end
        w  = 16 >> m_mode;
        nl = 1 << m_mode;
        for (int k = 0; k < nl; k++) begin
            v = (longint'(c) >> (k * w)) & ((longint'(1) << w) - 1);
            if (m_sgn && v >= (longint'(1) << (w - 1)))
                v = v - (longint'(1) << w);
            m_sum[k] = m_sum[k] + v;
        end
        if (last) begin
            for (int k = 0; k < nl; k++) begin
                e.d    = m_sum[k][ACC_W-1:0];
                e.lane = 2'(k);
                e.last = (k == nl - 1);
                q.push_back(e);
            end
            model_clear();
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid) begin
                chk("in_ready_low_in_drain", in_ready, 0);
                if (out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got lane %0d data 0x%0h, expected no beat",
                                 out_lane, out_data);
                    end else begin
                        e = q.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_lane", out_lane, e.lane);
                        chk("out_last", out_last, e.last);
                    end
                end
            end
        end
    endtask

    task automatic ready_gen();
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    endtask

    task automatic send_beat(input logic [15:0] c, input int mode, input bit sgn, input bit last);
        int n = 0;
        @(posedge clk);
        #1;
        in_c      = c;
        in_mode   = 2'(mode);
        in_signed = sgn;
        in_last   = last;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_handshake_timeout: got in_ready=0, expected 1 within 500 cycles");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            model_beat(c, mode, sgn, last);
            if (last) begin
                @(negedge clk);
                chk("out_valid_after_last", out_valid, 1);
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending, expected 0", q.size());
        end
    endtask

    initial begin
        logic [ACC_W-1:0] s_d;
        logic [1:0]       s_l;
        logic             s_la;
        int               nb;

        reset     = 1'b1;
        in_c      = '0;
        in_mode   = 2'd0;
        in_signed = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        rdy_mode  = 0;
        model_clear();

        fork
            monitor();
            ready_gen();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_lane",  out_lane,  0);
        chk("rst_out_last",  out_last,  0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);

        // Four signed nibbles, single beat
        send_beat(16'hF731, 2, 1, 1);
        wait_drain();

        // Two unsigned bytes over two beats
        send_beat(16'h80FF, 1, 0, 0);
        send_beat(16'h0101, 1, 0, 1);
        wait_drain();

        // Signed 16-bit lane, three beats of the most negative value
        send_beat(16'h8000, 0, 1, 0);
        send_beat(16'h8000, 0, 1, 0);
        send_beat(16'h8000, 0, 1, 1);
        wait_drain();

        // Mode changes mid-group: still four lanes, unsigned
        send_beat(16'h1234, 2, 0, 0);
        send_beat(16'h5678, 0, 1, 1);
        wait_drain();

        // Reserved mode behaves as mode 0
        send_beat(16'hFFFE, 3, 1, 1);
        wait_drain();

        // Backpressure: outputs stable while out_ready is low
        rdy_mode = 1;
        send_beat(16'h9A3C, 2, 1, 1);
        s_d  = out_data;
        s_l  = out_lane;
        s_la = out_last;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid",    out_valid, 1);
            chk("stall_data",     out_data,  s_d);
            chk("stall_lane",     out_lane,  s_l);
            chk("stall_last",     out_last,  s_la);
            chk("stall_in_ready", in_ready,  0);
        end
        rdy_mode = 0;
        wait_drain();

        // Reset while lane 1 is being presented
        rdy_mode = 1;
        send_beat(16'h4321, 2, 0, 1);
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk);
        #2;
        chk("pre_reset_lane", out_lane, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_drops_valid", out_valid, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        model_clear();
        repeat (4) begin
            @(negedge clk);
            chk("no_valid_after_reset", out_valid, 0);
        end
        rdy_mode = 0;
        send_beat(16'h0000, 2, 0, 1);
        wait_drain();

        // Reset in the middle of a group discards the partial sums
        send_beat(16'h7777, 1, 1, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_clear();
        send_beat(16'h0102, 1, 0, 1);
        wait_drain();

        // Random groups
        for (int g = 0; g < 40; g++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++)
                send_beat(16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)), b == nb - 1);
        end
        wait_drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
